metastable_entropy_harvester: RTL and testbench

Consumes the free-running `metastable` output of a metastable oscillator and turns it into debiased random words for the system clock domain. It synchronises and samples the raw bit and removes bias with a von Neumann extractor. It packs the result into WIDTH-bit words offered over a valid/ready handshake. A repetition-count health test blocks output when the source sticks.

---
 rtl/metastable_entropy_harvester.sv | 117 +++++++++++
 tb/tb_metastable_entropy_harvester.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/metastable_entropy_harvester.sv
// Turns a raw metastable oscillator bit into debiased WIDTH-bit words behind a valid/ready slot.
// A repetition-count health test permanently blocks output if the source sticks.
module metastable_entropy_harvester #(
    parameter int WIDTH        = 16,
    parameter int SAMPLE_DIV   = 4,
    parameter int REPEAT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             metastable,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             health_error
);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REPEAT_LIMIT + 1);

    localparam logic PAIR_EMPTY = 1'b0;
    localparam logic PAIR_HALF  = 1'b1;

    (* keep = "true", ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

    logic          sync_bit;
    logic [DW-1:0] div;
    logic          strobe;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          prev_raw;
    logic          trip;
    logic          pair_st;
    logic          first_bit;
    logic          emit;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0] cnt;
    logic          full;
    logic          load;

    assign sync_bit = sync_ff[1];
    assign strobe   = (div == DW'(SAMPLE_DIV - 1));
    assign full     = (cnt == CW'(WIDTH));
    assign emit     = strobe && (pair_st == PAIR_HALF) && (first_bit != sync_bit);
    assign trip     = strobe && (rep_nxt == RW'(REPEAT_LIMIT));
    // a trip on the same edge as a load suppresses the load so no word escapes
    assign load     = full && (!valid || ready) && !health_error && !trip;

    always_comb begin
        rep_nxt = rep_cnt;
        if (rep_cnt == '0 || sync_bit != prev_raw)
            rep_nxt = RW'(1);
        else if (rep_cnt != RW'(REPEAT_LIMIT))
            rep_nxt = rep_cnt + RW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= 2'b00;
        else     sync_ff <= {sync_ff[0], metastable};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         div <= '0;
        else if (strobe) div <= '0;
        else             div <= div + DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt      <= '0;
            prev_raw     <= 1'b0;
            health_error <= 1'b0;
        end else if (strobe) begin
            rep_cnt  <= rep_nxt;
            prev_raw <= sync_bit;
            if (trip) health_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_st   <= PAIR_EMPTY;
            first_bit <= 1'b0;
        end else if (strobe) begin
            if (pair_st == PAIR_EMPTY) begin
                first_bit <= sync_bit;
                pair_st   <= PAIR_HALF;
            end else begin
                pair_st   <= PAIR_EMPTY;
            end
        end
    end

    // von Neumann: pair 10 yields 1 and 01 yields 0, i.e. the first bit of an unequal pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            shift <= '0;
            cnt   <= '0;
        end else if (health_error) begin
            data  <= '0;
            valid <= 1'b0;
            shift <= '0;
            cnt   <= '0;
        end else if (load) begin
            data  <= shift;
            valid <= 1'b1;
            shift <= '0;
            cnt   <= '0;
        end else begin
            if (valid && ready) valid <= 1'b0;
            if (emit && !full) begin
                shift <= {shift[WIDTH-2:0], first_bit};
                cnt   <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_metastable_entropy_harvester.sv
// Bench for metastable_entropy_harvester: directed segments plus random segments, each replayed
// through a per-edge reference model built from the sample/pair/word rules.
module tb_metastable_entropy_harvester;
    localparam int W    = 8;
    localparam int LIM  = 32;
    localparam int MAXE = 512;

    logic clk = 1'b0;
    logic rst, metastable, ready;
    logic [W-1:0] data1, data4;
    logic valid1, valid4, herr1, herr4;

    always #5 clk = ~clk;

    metastable_entropy_harvester #(.WIDTH(W), .SAMPLE_DIV(1), .REPEAT_LIMIT(LIM)) dut1 (
        .clk(clk), .rst(rst), .metastable(metastable), .data(data1),
        .valid(valid1), .ready(ready), .health_error(herr1));

    metastable_entropy_harvester #(.WIDTH(W), .SAMPLE_DIV(4), .REPEAT_LIMIT(LIM)) dut4 (
        .clk(clk), .rst(rst), .metastable(metastable), .data(data4),
        .valid(valid4), .ready(ready), .health_error(herr4));

    // m_arr[e]/r_arr[e]: metastable and ready present at rising edge e after reset release
    logic         m_arr [0:MAXE];
    logic         r_arr [0:MAXE];
    logic         v1 [0:MAXE];
    logic [W-1:0] d1 [0:MAXE];
    logic         h1 [0:MAXE];
    logic         v4 [0:MAXE];
    logic [W-1:0] d4 [0:MAXE];
    logic         h4 [0:MAXE];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input int n);
        @(negedge clk); rst = 1'b1; metastable = 1'b0; ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int e = 1; e <= n; e++) begin
            metastable = m_arr[e];
            ready      = r_arr[e];
            @(posedge clk); #1;
            v1[e] = valid1; d1[e] = data1; h1[e] = herr1;
            v4[e] = valid4; d4[e] = data4; h4[e] = herr4;
            @(negedge clk);
        end
    endtask

    task automatic set_pair(input int k, input logic b);
        m_arr[2*k-1] = b;
        m_arr[2*k]   = ~b;
    endtask

    function automatic logic [W-1:0] word_of_pairs(input int k0);
        logic [W-1:0] w;
        w = '0;
        for (int k = k0; k < k0 + W; k++) w = {w[W-2:0], m_arr[2*k-1]};
        return w;
    endfunction

    task automatic fill(input int n, input int rmode);
        for (int e = 1; e <= n; e++) begin
            m_arr[e] = 1'($urandom_range(0, 1));
            r_arr[e] = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    endtask

    // Sample stream -> bit stream -> words, with the one-word output slot and health gating.
    task automatic model_check(input int n, input int sd, input string tag);
        int run;
        logic prev, herr, hasf, fb, val, raw, trip, emit, b, load;
        logic [W-1:0] dat;
        logic bq[$];
        logic ov, oh;
        logic [W-1:0] od;
        run = 0; prev = 0; herr = 0; hasf = 0; fb = 0; val = 0; dat = '0;
        bq.delete();
        for (int e = 1; e <= n; e++) begin
            trip = 0; emit = 0; b = 0;
            if (e % sd == 0) begin
                raw = (e >= 3) ? m_arr[e-2] : 1'b0;
                if (run == 0 || raw != prev) run = 1;
                else if (run < LIM) run++;
                prev = raw;
                if (run == LIM) trip = 1;
                if (!hasf) begin
                    fb = raw; hasf = 1;
                end else begin
                    hasf = 0;
                    if (fb != raw) begin emit = 1; b = fb; end
                end
            end
            if (herr) begin
                val = 0; dat = '0; bq.delete();
            end else begin
                load = (bq.size() == W) && (!val || r_arr[e]) && !trip;
                if (load) begin
                    dat = '0;
                    foreach (bq[i]) dat = {dat[W-2:0], bq[i]};
                    val = 1;
                    bq.delete();
                end else begin
                    if (val && r_arr[e]) val = 0;
                    if (emit && bq.size() < W) bq.push_back(b);
                end
            end
            if (trip) herr = 1;
            ov = (sd == 1) ? v1[e] : v4[e];
            oh = (sd == 1) ? h1[e] : h4[e];
            od = (sd == 1) ? d1[e] : d4[e];
            chk($sformatf("%s_sd%0d_valid@%0d", tag, sd, e), ov, val);
            chk($sformatf("%s_sd%0d_herr@%0d", tag, sd, e), oh, herr);
            if (val) chk($sformatf("%s_sd%0d_data@%0d", tag, sd, e), od, dat);
        end
    endtask

    initial begin
        int pulses, found;
        logic [W-1:0] pw, expw;
        logic [15:0] pat;
        logic pb [1:12];
        logic anyh;

        rst = 1'b1; metastable = 1'b0; ready = 1'b0;
        #2;
        chk("rst_valid1", valid1, 0); chk("rst_data1", data1, 0); chk("rst_herr1", herr1, 0);
        chk("rst_valid4", valid4, 0); chk("rst_data4", data4, 0); chk("rst_herr4", herr4, 0);

        // known pairs 01 10 01 01 10 10 01 10 then only discarded pairs
        pat = 16'b0110_0101_1010_0110;
        for (int i = 0; i < 16; i++) m_arr[i+1] = pat[15-i];
        for (int e = 17; e <= 40; e++) m_arr[e] = 1'(((e - 17) / 2) % 2);
        for (int e = 1; e <= 40; e++) r_arr[e] = 1'b1;
        play(40);
        pulses = 0; pw = '0;
        for (int e = 1; e <= 40; e++) if (v1[e]) begin pulses++; pw = d1[e]; end
        chk("t1_pulses", pulses, 1);
        chk("t1_word", pw, 8'h4D);
        chk("t1_herr", h1[40], 0);
        model_check(40, 1, "t1"); model_check(40, 4, "t1");

        // 00/11 pairs interleaved with eight 01 pairs
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 1)            begin m_arr[2*k+1] = 0; m_arr[2*k+2] = 1; end
            else if ((k / 2) % 2 == 0) begin m_arr[2*k+1] = 0; m_arr[2*k+2] = 0; end
            else                       begin m_arr[2*k+1] = 1; m_arr[2*k+2] = 1; end
        end
        for (int e = 33; e <= 50; e++) m_arr[e] = 1'(((e - 33) / 2) % 2);
        for (int e = 1; e <= 50; e++) r_arr[e] = 1'b1;
        play(50);
        pulses = 0; pw = 8'hFF;
        for (int e = 1; e <= 50; e++) if (v1[e]) begin pulses++; pw = d1[e]; end
        chk("t2_pulses", pulses, 1);
        chk("t2_word", pw, 8'h00);
        model_check(50, 1, "t2"); model_check(50, 4, "t2");

        // backpressure: hold, one-cycle ready, hold, then drain
        for (int k = 1; k <= 60; k++) set_pair(k, 1'($urandom_range(0, 1)));
        for (int e = 1; e <= 120; e++) r_arr[e] = (e == 81) || (e > 100);
        play(120);
        chk("t3_hold_valid", v1[80], 1);
        chk("t3_hold_word", d1[80], word_of_pairs(1));
        chk("t3_second_valid", v1[81], 1);
        chk("t3_second_word", d1[81], word_of_pairs(9));
        chk("t3_third_word", d1[101], word_of_pairs(40));
        model_check(120, 1, "t3"); model_check(120, 4, "t3");

        // stuck-at-0 from reset: 32nd strobe trips
        for (int e = 1; e <= 140; e++) begin m_arr[e] = 1'b0; r_arr[e] = 1'b1; end
        play(140);
        chk("t4_sd1_before", h1[31], 0); chk("t4_sd1_trip", h1[32], 1);
        chk("t4_sd4_before", h4[127], 0); chk("t4_sd4_trip", h4[128], 1);
        model_check(140, 1, "t4"); model_check(140, 4, "t4");

        // pending word discarded one edge after the trip
        for (int k = 1; k <= 7; k++) set_pair(k, 1'($urandom_range(0, 1)));
        set_pair(8, 1'b0);
        for (int e = 17; e <= 60; e++) m_arr[e] = 1'b0;
        for (int e = 1; e <= 60; e++) r_arr[e] = 1'b0;
        play(60);
        chk("t4b_before", h1[49], 0); chk("t4b_trip", h1[50], 1);
        chk("t4b_valid_at_trip", v1[50], 1); chk("t4b_valid_after", v1[51], 0);
        model_check(60, 1, "t4b"); model_check(60, 4, "t4b");

        // 31 identical samples then a toggle: no trip
        for (int e = 1; e <= 29; e++) m_arr[e] = 1'b0;
        m_arr[30] = 1'b1;
        for (int k = 16; k <= 45; k++) set_pair(k, 1'($urandom_range(0, 1)));
        for (int e = 1; e <= 90; e++) r_arr[e] = 1'b1;
        play(90);
        anyh = 1'b0;
        for (int e = 1; e <= 90; e++) anyh = anyh | h1[e];
        chk("t4c_no_trip", anyh, 0);
        model_check(90, 1, "t4c");

        // SAMPLE_DIV=4: noise between strobes must not reach the word
        for (int j = 1; j <= 12; j++) pb[j] = 1'($urandom_range(0, 1));
        expw = '0;
        for (int j = 1; j <= W; j++) expw = {expw[W-2:0], pb[j]};
        for (int pass = 0; pass < 2; pass++) begin
            fill(100, 0);
            for (int j = 1; j <= 12; j++) begin m_arr[8*j-6] = pb[j]; m_arr[8*j-2] = ~pb[j]; end
            play(100);
            found = 0; pw = '0;
            for (int e = 1; e <= 100; e++) if (v4[e] && found == 0) begin found = 1; pw = d4[e]; end
            chk($sformatf("t5_found_%0d", pass), found, 1);
            chk($sformatf("t5_word_%0d", pass), pw, expw);
            model_check(100, 1, "t5"); model_check(100, 4, "t5");
        end

        // asynchronous reset between edges with a word held and a partial word in flight
        for (int k = 1; k <= 20; k++) set_pair(k, 1'($urandom_range(0, 1)));
        for (int e = 1; e <= 40; e++) r_arr[e] = 1'b0;
        play(40);
        model_check(40, 1, "t6"); model_check(40, 4, "t6");
        chk("t6_valid_pre", valid1, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid1", valid1, 0); chk("t6_data1", data1, 0); chk("t6_herr1", herr1, 0);
        chk("t6_valid4", valid4, 0); chk("t6_data4", data4, 0);

        for (int it = 0; it < 3; it++) begin
            fill(300, 2);
            play(300);
            model_check(300, 1, $sformatf("rnd%0d", it));
            model_check(300, 4, $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
